// File: rtl/dmem_bridge_if.sv
// Split address/data handshake bus between the data-memory bridge
// and data memory.
interface dmem_bridge_if #(
  parameter int ADDR_WD = 64
) ();
  logic               req;
  logic               wr;
  logic [1:0]         size;
  logic [ADDR_WD-1:0] addr;
  logic [7:0]         wstrb;
  logic [63:0]        wdata;
  logic               addr_ok;
  logic               data_ok;
  logic [63:0]        rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// EX->MEM data-memory bridge: issues one bus access per EX load/store,
// stalls the front of the pipe meanwhile and holds the read word for MEM.
module dmem_bridge #(
  parameter int ADDR_WD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               ex_req_en,
  input  logic               ex_req_we,
  input  logic [3:0]         ex_size,
  input  logic [ADDR_WD-1:0] ex_addr,
  input  logic [63:0]        ex_wdata,
  output logic               stall_req,
  output logic               lsu_misalign,
  output logic [63:0]        data_sram_rdata,
  dmem_bridge_if.master      dbus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               we_q, we_d;
  logic [7:0]         strb_q, strb_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        rdata_q, rdata_d;

  logic               mis;
  logic               accept;
  logic [1:0]         size_enc;
  logic [7:0]         strb_ex;
  logic [63:0]        wdata_ex;
  logic               unused_stall;

  // only the EX/MEM hold bit matters to this block
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // decode EX size into bus size, alignment, strobes and lane data
  always_comb begin
    mis      = 1'b0;
    size_enc = 2'd0;
    strb_ex  = 8'h00;
    wdata_ex = ex_wdata;
    unique case (1'b1)
      ex_size[0]: begin
        size_enc = 2'd0;
        strb_ex  = 8'h01 << ex_addr[2:0];
        wdata_ex = {8{ex_wdata[7:0]}};
      end
      ex_size[1]: begin
        size_enc = 2'd1;
        mis      = ex_addr[0];
        strb_ex  = 8'h03 << {ex_addr[2:1], 1'b0};
        wdata_ex = {4{ex_wdata[15:0]}};
      end
      ex_size[2]: begin
        size_enc = 2'd2;
        mis      = |ex_addr[1:0];
        strb_ex  = 8'h0F << {ex_addr[2], 2'b00};
        wdata_ex = {2{ex_wdata[31:0]}};
      end
      ex_size[3]: begin
        size_enc = 2'd3;
        mis      = |ex_addr[2:0];
        strb_ex  = 8'hFF;
        wdata_ex = ex_wdata;
      end
      default: begin
        mis      = 1'b0;
      end
    endcase
  end

  assign lsu_misalign = ex_req_en & mis;
  assign accept = (state_q == IDLE) & ex_req_en & ~mis;

  // access sequencing and request/read-data capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = ex_addr;
          size_d  = size_enc;
          we_d    = ex_req_we;
          strb_d  = strb_ex;
          wdata_d = wdata_ex;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dbus.addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (dbus.data_ok) begin
          rdata_d = dbus.rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!stall[3]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_req = (state_q == REQ) | (state_q == WAIT) | accept;

  assign dbus.req   = (state_q == REQ);
  assign dbus.wr    = we_q;
  assign dbus.size  = size_q;
  assign dbus.addr  = addr_q;
  assign dbus.wstrb = strb_q;
  assign dbus.wdata = wdata_q;

  assign data_sram_rdata = rdata_q;

  // state and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access bridge between the EX and MEM pipeline stages. It takes the load/store request that EX issues for the instruction currently in EX, drives a split address/data handshake bus to data memory, and raises a stall request while the access is outstanding. It presents the 64-bit read word to MEM as `data_sram_rdata`, held stable for the cycle in which MEM extracts and extends the selected bytes.

## Interface
- `ADDR_WD`, 64: width of `ex_addr` and `dbus_addr`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  6  pipeline stall vector from control; `stall[3]` = EX/MEM register held.
- `ex_req_en`  in  1  instruction in EX performs a memory access.
- `ex_req_we`  in  1  1 = store, 0 = load.
- `ex_size`  in  4  one-hot size: [0] byte, [1] half, [2] word, [3] double.
- `ex_addr`  in  ADDR_WD  effective byte address.
- `ex_wdata`  in  64  store data, right-aligned.
- `stall_req`  out  1  request to control to stall IF..EX.
- `lsu_misalign`  out  1  combinational; current EX request is misaligned.
- `data_sram_rdata`  out  64  registered read word to MEM.
- `dbus_req`  out  1  bus request valid.
- `dbus_wr`  out  1  bus write.
- `dbus_size`  out  2  0 = byte, 1 = half, 2 = word, 3 = double.
- `dbus_addr`  out  ADDR_WD  byte address.
- `dbus_wstrb`  out  8  byte strobes within the 8-byte lane.
- `dbus_wdata`  out  64  lane-replicated store data.
- `dbus_addr_ok`  in  1  request accepted this cycle.
- `dbus_data_ok`  in  1  response (read data / write ack) this cycle.
- `dbus_rdata`  in  64  read data, valid with `dbus_data_ok`.

## Operation
- **Misalignment:**
  - Half with `addr[0]` set, word with `addr[1:0]` nonzero, or double with `addr[2:0]` nonzero sets `lsu_misalign` = 1.
  - A misaligned request starts no bus transaction and raises no stall.
- **Strobes:**
  - Byte: `1 << addr[2:0]`.
  - Half: `8'h03 << {addr[2:1],1'b0}`.
  - Word: `8'h0F << {addr[2],2'b00}`.
  - Double: `8'hFF`.
  - Loads drive the same strobe value; the bus ignores it for reads.
- **Write data:** byte replicated ×8, half ×4, word ×2, double as-is.
- **FSM states:** IDLE, REQ, WAIT, DONE.
  - IDLE: on a valid `ex_req_en` that is not misaligned, latch addr, size, we, strobe and data into request registers, then go to REQ.
  - REQ: `dbus_req` = 1 with all bus fields driven from the request registers. On `dbus_addr_ok`, go to WAIT.
  - WAIT: on `dbus_data_ok`, capture `dbus_rdata` into `data_sram_rdata` (loads and stores alike), then go to DONE.
  - DONE: if `stall[3]` = 0, go to IDLE. Otherwise stay in DONE and issue no new request.
- **stall_req:**
  - 1 when state is REQ or WAIT.
  - 1 when state is IDLE and a valid non-misaligned `ex_req_en` is present.
  - 0 in DONE.
- **Read-data hold:** `data_sram_rdata` changes only on a captured `dbus_data_ok`. It therefore holds through the cycle after the EX→MEM advance.
- **Stray responses:** `dbus_data_ok` in IDLE, REQ or DONE is ignored, including a response that was outstanding across a reset.
- **Request stability:** bus fields stay stable while `dbus_req` = 1 and `dbus_addr_ok` = 0.

## Timing
- **Reset values:** state IDLE; `dbus_req`, `stall_req` = 0; `data_sram_rdata` = 0; request registers = 0.
- **Reset mid-transaction:** return to IDLE with no new request for that access. Reset has priority over every transition.
- **Request timing:** `dbus_req` is asserted the cycle after the request is seen in IDLE. It is never asserted combinationally from EX inputs.
- **Minimum access (addr_ok in the first REQ cycle, data_ok the next cycle):**
  - cycle 0: IDLE, stall_req = 1
  - cycle 1: REQ
  - cycle 2: WAIT, data_ok
  - cycle 3: DONE, stall_req = 0, EX→MEM advances at the end of this cycle
  - cycle 4: MEM reads `data_sram_rdata`
- **Same-cycle response:** `dbus_addr_ok` and `dbus_data_ok` in the same cycle is illegal from the bus. `dbus_data_ok` in REQ is ignored.
- **Back-to-back accesses:**
  - A new request is taken in the IDLE cycle right after DONE.
  - The earliest next capture is 3 cycles later, so MEM's read of the previous word is never overwritten.

## Test plan
- Load word at `0x1004`, addr_ok after 0 waits, data_ok next cycle with rdata `0xAABBCCDD_11223344` -> `dbus_wstrb` = `8'hF0`, `dbus_size` = 2, `stall_req` high 3 cycles, `data_sram_rdata` = `0xAABBCCDD_11223344` from cycle 3.
- Store byte `0x5A` at `0x2003` -> `dbus_wr` = 1, `dbus_wstrb` = `8'h08`, `dbus_wdata` = `0x5A5A5A5A_5A5A5A5A`.
- Half load at `0x3001` -> `lsu_misalign` = 1, `dbus_req` stays 0, `stall_req` = 0.
- Double load with addr_ok delayed 3 cycles and data_ok delayed 2 more -> `dbus_req` and its fields stable for 4 cycles, `stall_req` high 7 cycles in total, capture on data_ok.
- In DONE with `stall[3]` held high for 2 cycles by a later stage -> stays DONE, no `dbus_req`, `data_sram_rdata` unchanged, IDLE after release.
- Assert `rst` in WAIT, then pulse `dbus_data_ok` in IDLE -> state IDLE, `data_sram_rdata` = 0, no capture, `stall_req` = 0.
